overture_regfile: RTL and testbench

OVERTURE_REGFILE -- requirements
Module: overture_regfile

---
 rtl/overture_pkg.sv | 32 +++
 rtl/overture_cond_eval.sv | 32 +++
 rtl/overture_regfile.sv | 222 ++++++++++++++++++++++
 tb/tb_overture_regfile.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/overture_pkg.sv
// Shared encodings for the overture register file: instruction modes, condition codes,
// FSM states and register-file geometry.
package overture_pkg;

  localparam int REG_COUNT = 6;
  localparam int IO_INDEX  = 6;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_CALC = 2'b01,
    MODE_COPY = 2'b10,
    MODE_COND = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'b000,
    COND_EQ     = 3'b001,
    COND_LT     = 3'b010,
    COND_LE     = 3'b011,
    COND_ALWAYS = 3'b100,
    COND_NE     = 3'b101,
    COND_GE     = 3'b110,
    COND_GT     = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_e;

endpackage

// File: rtl/overture_cond_eval.sv
// Combinational branch-condition decode: tests an 8-bit two's-complement value
// against one of eight condition codes.
module overture_cond_eval
  import overture_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [2:0] code_i,
  output logic       taken_o
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (value_i == 8'h00);
  assign is_neg  = value_i[7];

  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(code_i))
      COND_NEVER:  taken_o = 1'b0;
      COND_EQ:     taken_o = is_zero;
      COND_LT:     taken_o = is_neg;
      COND_LE:     taken_o = is_neg | is_zero;
      COND_ALWAYS: taken_o = 1'b1;
      COND_NE:     taken_o = !is_zero;
      COND_GE:     taken_o = !is_neg;
      COND_GT:     taken_o = !is_neg && !is_zero;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/overture_regfile.sv
// Six-entry register file with immediate/calculate/copy/condition instructions.
// Port-mapped I/O on index 6 is compiled in only when OVERTURE_IO_EN is defined.
module overture_regfile
  import overture_pkg::*;
#(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Instruction,
  input  logic       Instr_Valid,
  output logic       Instr_Ready,
  input  logic [7:0] ALU_Result,
  output logic [7:0] Input_1,
  output logic [7:0] Input_2,
  output logic [7:0] Reg0,
  output logic [7:0] Reg3,
  output logic       Jump,
  output logic [7:0] Jump_Target,
  input  logic [7:0] In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic [7:0] Out_Data,
  output logic       Out_Valid,
  input  logic       Out_Ready
);

  state_e     state_q, state_d;
  logic [7:0] reg_val [REG_COUNT];
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_data;
  logic       route_en;
  logic [2:0] route_dst;
  logic [7:0] route_data;
  logic [7:0] src_val;
  logic       taken;
  logic       accept;
  logic       jump_q, jump_d;
  logic [7:0] jump_target_q, jump_target_d;
  logic [2:0] src_idx, dst_idx;

`ifdef OVERTURE_IO_EN
  logic       in_ready;
  logic [2:0] wait_dst_q, wait_dst_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
`endif

  assign src_idx = Instruction[5:3];
  assign dst_idx = Instruction[2:0];
  assign accept  = Instr_Valid && Instr_Ready;

  overture_cond_eval u_cond (
    .value_i (reg_val[3]),
    .code_i  (Instruction[2:0]),
    .taken_o (taken)
  );

  // Index 7 (and 6 without I/O) reads as zero.
  always_comb begin
    src_val = 8'h00;
    if (src_idx < 3'(REG_COUNT)) begin
      src_val = reg_val[src_idx];
    end
`ifdef OVERTURE_IO_EN
    else if (src_idx == 3'(IO_INDEX)) begin
      src_val = In_Data;
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    jump_d        = 1'b0;
    jump_target_d = jump_target_q;
    wr_en         = 1'b0;
    wr_idx        = 3'd0;
    wr_data       = 8'h00;
    route_en      = 1'b0;
    route_dst     = dst_idx;
    route_data    = src_val;
`ifdef OVERTURE_IO_EN
    in_ready      = 1'b0;
    wait_dst_d    = wait_dst_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (mode_e'(Instruction[7:6]))
            MODE_IMM: begin
              wr_en   = 1'b1;
              wr_idx  = 3'd0;
              wr_data = {2'b00, Instruction[5:0]};
            end
            MODE_CALC: begin
              wr_en   = 1'b1;
              wr_idx  = 3'd3;
              wr_data = ALU_Result;
            end
            MODE_COPY: begin
`ifdef OVERTURE_IO_EN
              if (src_idx == 3'(IO_INDEX) && !In_Valid) begin
                wait_dst_d = dst_idx;
                state_d    = ST_WAIT_IN;
              end else begin
                in_ready = (src_idx == 3'(IO_INDEX));
                route_en = 1'b1;
              end
`else
              route_en = 1'b1;
`endif
            end
            MODE_COND: begin
              if (taken) begin
                jump_d        = 1'b1;
                jump_target_d = reg_val[0];
              end
            end
            default: ;
          endcase
        end
      end
`ifdef OVERTURE_IO_EN
      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (In_Valid) begin
          state_d    = ST_RUN;
          route_en   = 1'b1;
          route_dst  = wait_dst_q;
          route_data = In_Data;
        end
      end
      ST_WAIT_OUT: begin
        if (Out_Ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase

    // A completed copy lands either in the output port or the register write port;
    // indices with no backing register simply match nothing below.
    if (route_en) begin
`ifdef OVERTURE_IO_EN
      if (route_dst == 3'(IO_INDEX)) begin
        out_data_d  = route_data;
        out_valid_d = 1'b1;
        state_d     = ST_WAIT_OUT;
      end else
`endif
      begin
        wr_en   = 1'b1;
        wr_idx  = route_dst;
        wr_data = route_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      jump_q        <= 1'b0;
      jump_target_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      jump_q        <= jump_d;
      jump_target_q <= jump_target_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
    logic [7:0] data_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= 8'h00;
      end else if (wr_en && wr_idx == 3'(gi)) begin
        data_q <= wr_data;
      end
    end
    assign reg_val[gi] = data_q;
  end

`ifdef OVERTURE_IO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_dst_q  <= 3'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      wait_dst_q  <= wait_dst_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_Ready  = in_ready;
  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
`else
  logic unused_io;
  assign unused_io = ^{In_Data, In_Valid, Out_Ready};
  assign In_Ready  = 1'b0;
  assign Out_Data  = 8'h00;
  assign Out_Valid = 1'b0;
`endif

  assign Instr_Ready = (state_q == ST_RUN);
  assign Input_1     = reg_val[1];
  assign Input_2     = reg_val[2];
  assign Reg0        = reg_val[0];
  assign Reg3        = reg_val[3];
  assign Jump        = jump_q;
  assign Jump_Target = jump_target_q;

endmodule

// File: tb/tb_overture_regfile.sv
// Randomized self-checking bench for overture_regfile against an array-based reference model;
// the port-mapped I/O scenarios run only when OVERTURE_IO_EN is defined.
module tb_overture_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Instruction;
  logic       Instr_Valid;
  logic       Instr_Ready;
  logic [7:0] ALU_Result;
  logic [7:0] Input_1, Input_2, Reg0, Reg3;
  logic       Jump;
  logic [7:0] Jump_Target;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_reg [6];
  logic       m_jump;
  logic [7:0] m_jt;

  overture_regfile #(.UUID(1), .NAME("dut")) dut (
    .clk         (clk),
    .rst         (rst),
    .Instruction (Instruction),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .ALU_Result  (ALU_Result),
    .Input_1     (Input_1),
    .Input_2     (Input_2),
    .Reg0        (Reg0),
    .Reg3        (Reg3),
    .Jump        (Jump),
    .Jump_Target (Jump_Target),
    .In_Data     (In_Data),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Out_Data    (Out_Data),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] code, input logic [7:0] r3);
    int x;
    x = $signed(r3);
    case (code)
      3'd0: return 1'b0;
      3'd1: return x == 0;
      3'd2: return x < 0;
      3'd3: return x <= 0;
      3'd4: return 1'b1;
      3'd5: return x != 0;
      3'd6: return x >= 0;
      default: return x > 0;
    endcase
  endfunction

  task automatic check_visible();
    check("reg0", Reg0, m_reg[0]);
    check("reg1", Input_1, m_reg[1]);
    check("reg2", Input_2, m_reg[2]);
    check("reg3", Reg3, m_reg[3]);
    check("jump", Jump, m_jump);
    check("jump_target", Jump_Target, m_jt);
    check("in_ready", In_Ready, 8'd0);
    check("out_valid", Out_Valid, 8'd0);
    check("out_data", Out_Data, 8'd0);
  endtask

  // Called at a falling edge: drives one instruction, predicts the next-cycle state, checks it.
  task automatic issue(input bit v, input logic [7:0] ins, input logic [7:0] alu);
    logic [7:0] nreg [6];
    int s, d;
    logic [7:0] val;
    Instr_Valid = v;
    Instruction = ins;
    ALU_Result  = alu;
    check("instr_ready", Instr_Ready, 8'd1);
    nreg   = m_reg;
    m_jump = 1'b0;
    if (v) begin
      case (ins[7:6])
        2'b00: nreg[0] = {2'b00, ins[5:0]};
        2'b01: nreg[3] = alu;
        2'b10: begin
          s   = int'(ins[5:3]);
          d   = int'(ins[2:0]);
          val = (s < 6) ? m_reg[s] : 8'h00;
          if (d < 6) nreg[d] = val;
        end
        default: begin
          if (cond_true(ins[2:0], m_reg[3])) begin
            m_jump = 1'b1;
            m_jt   = m_reg[0];
          end
        end
      endcase
    end
    @(negedge clk);
    m_reg = nreg;
    $display("txn v=%0d ins=%h alu=%h -> r0=%h r1=%h r2=%h r3=%h jump=%0d", v, ins, alu,
             Reg0, Input_1, Input_2, Reg3, Jump);
    check_visible();
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    foreach (m_reg[i]) m_reg[i] = 8'h00;
    m_jump = 1'b0;
    m_jt   = 8'h00;
    check("rst_instr_ready", Instr_Ready, 8'd1);
    check("rst_out_valid", Out_Valid, 8'd0);
    check("rst_reg0", Reg0, 8'h00);
    check("rst_reg3", Reg3, 8'h00);
    check("rst_reg1", Input_1, 8'h00);
    check("rst_reg2", Input_2, 8'h00);
    check("rst_jump", Jump, 8'd0);
    check("rst_jump_target", Jump_Target, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ins;
    rst = 1'b1;
    Instruction = 8'h00; Instr_Valid = 1'b0; ALU_Result = 8'h00;
    In_Data = 8'h00; In_Valid = 1'b0; Out_Ready = 1'b0;
    foreach (m_reg[i]) m_reg[i] = 8'h00;
    m_jump = 1'b0;
    m_jt   = 8'h00;
    #3;
    check("por_instr_ready", Instr_Ready, 8'd1);
    check_visible();
    @(negedge clk);
    rst = 1'b0;

    // Immediate then copy 0->1
    issue(1'b1, 8'h2A, 8'h00);
    check("imm_reg0", Reg0, 8'h2A);
    issue(1'b1, 8'h81, 8'h00);
    check("copy_reg1", Input_1, 8'h2A);

    // reg1=5, reg2=3, calculate with ALU 0x08
    issue(1'b1, 8'h05, 8'h00);
    issue(1'b1, 8'h81, 8'h00);
    issue(1'b1, 8'h03, 8'h00);
    issue(1'b1, 8'h82, 8'h00);
    check("alu_in1", Input_1, 8'h05);
    check("alu_in2", Input_2, 8'h03);
    issue(1'b1, 8'h40, 8'h08);
    check("calc_reg3", Reg3, 8'h08);

    // reg3=0xFF: <0 is taken, >0 is not; src 7 reads 0, dst 7 discarded
    issue(1'b1, 8'h40, 8'hFF);
    issue(1'b1, 8'h11, 8'h00);
    issue(1'b1, 8'hC2, 8'h00);
    check("jump_lt", Jump, 8'd1);
    check("jump_lt_target", Jump_Target, 8'h11);
    issue(1'b0, 8'hC2, 8'h00);
    check("jump_one_cycle", Jump, 8'd0);
    issue(1'b1, 8'hC7, 8'h00);
    check("jump_gt_none", Jump, 8'd0);
    issue(1'b1, 8'h87, 8'h00);
    issue(1'b1, 8'hB9, 8'h00);
    check("src7_zero", Input_1, 8'h00);

`ifndef OVERTURE_IO_EN
    // Without I/O: src 6 reads zero, dst 6 discarded
    issue(1'b1, 8'h15, 8'h00);
    issue(1'b1, 8'h84, 8'h00);
    issue(1'b1, 8'hB4, 8'h00);
    issue(1'b1, 8'hA1, 8'h00);
    check("noio_reg4", Input_1, 8'h00);
    issue(1'b1, 8'h86, 8'h00);
`endif

    for (int i = 0; i < 400; i++) begin
      ins = 8'($urandom);
`ifdef OVERTURE_IO_EN
      if (ins[7:6] == 2'b10 && ins[5:3] == 3'd6) ins[5:3] = 3'd7;
      if (ins[7:6] == 2'b10 && ins[2:0] == 3'd6) ins[2:0] = 3'd7;
`else
      In_Data   = 8'($urandom);
      In_Valid  = 1'($urandom);
      Out_Ready = 1'($urandom);
`endif
      issue($urandom_range(0, 3) != 0, ins, 8'($urandom));
    end
    In_Valid = 1'b0; Out_Ready = 1'b0;
    issue(1'b0, 8'h00, 8'h00);

`ifdef OVERTURE_IO_EN
    // Copy 6->2 stalls three cycles waiting for input
    Instr_Valid = 1'b1; Instruction = 8'hB2; In_Valid = 1'b0;
    @(negedge clk);
    Instr_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("io_wait_instr_ready", Instr_Ready, 8'd0);
      check("io_wait_in_ready", In_Ready, 8'd1);
      @(negedge clk);
    end
    In_Data = 8'h77; In_Valid = 1'b1;
    @(negedge clk);
    In_Valid = 1'b0;
    m_reg[2] = 8'h77;
    $display("txn io_in data=77 -> r2=%h", Input_2);
    check("io_in_reg2", Input_2, 8'h77);
    check("io_in_back_run", Instr_Ready, 8'd1);

    // Copy 2->6 with a completed output handshake
    Instr_Valid = 1'b1; Instruction = 8'h96; Out_Ready = 1'b0;
    @(negedge clk);
    Instr_Valid = 1'b0;
    check("io_out_valid", Out_Valid, 8'd1);
    check("io_out_data", Out_Data, 8'h77);
    check("io_out_stall", Instr_Ready, 8'd0);
    Out_Ready = 1'b1;
    @(negedge clk);
    Out_Ready = 1'b0;
    $display("txn io_out handshake -> out_valid=%0d", Out_Valid);
    check("io_out_done", Out_Valid, 8'd0);
    check("io_out_back_run", Instr_Ready, 8'd1);

    // Copy 3->6 abandoned by reset while waiting
    issue(1'b1, 8'h40, 8'h5C);
    Instr_Valid = 1'b1; Instruction = 8'h9E;
    @(negedge clk);
    Instr_Valid = 1'b0;
    check("io_abort_valid", Out_Valid, 8'd1);
    check("io_abort_data", Out_Data, 8'h5C);
    $display("txn io_abort reset in WAIT_OUT");
    reset_pulse();
    check("io_abort_out_data", Out_Data, 8'h00);
    issue(1'b0, 8'h00, 8'h00);
`endif

    // Asynchronous reset mid-run after loading state
    issue(1'b1, 8'h3F, 8'h00);
    issue(1'b1, 8'h40, 8'h80);
    issue(1'b1, 8'hC4, 8'h00);
    $display("txn async reset mid-run");
    reset_pulse();
    issue(1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
